// File: rtl/seq_divider_4bit_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// default operand/counter widths.
package seq_divider_4bit_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_4bit_if.sv
// Start/busy/done handshake and operand/result bus of the divide path.
interface seq_divider_4bit_if #(
  parameter int WIDTH = seq_divider_4bit_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_divider_4bit_subtractor.sv
// Combinational ripple-borrow subtractor built from full-subtractor cells;
// borrow-in of the LSB cell is tied low.
module subtractor_5bit #(
  parameter int W = seq_divider_4bit_pkg::WIDTH_DEF + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fs
      assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
      assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
    end
  endgenerate

  assign borrow_out = w_borrow[W];

endmodule

// File: rtl/seq_divider_4bit.sv
// Sequential unsigned restoring divider: one shift-and-subtract step per clock,
// results and flags registered, start/busy/done handshake.
module seq_divider_4bit
  import seq_divider_4bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider_4bit_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_a_step;
  logic [WIDTH-1:0] w_q_step;
  logic             w_borrow;
  logic             w_last;
  logic             w_div_zero;

  // A's MSB is always 0 after a step (A < M), so it falls off the shift.
  assign w_shift    = (WIDTH+1)'({r_a, r_q[WIDTH-1]});
  assign w_a_step   = w_borrow ? w_shift : w_diff;
  assign w_q_step   = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_div_zero = (bus.divisor == {WIDTH{1'b0}});

  subtractor_5bit #(.W(WIDTH + 1)) u_sub (
    .a          ({1'b0, {WIDTH{1'b0}}} | w_shift),
    .b          ({1'b0, r_m}),
    .diff       (w_diff),
    .borrow_out (w_borrow)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = w_div_zero ? DONE : CALC;
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = CALC;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= {(WIDTH+1){1'b0}};
      r_q    <= {WIDTH{1'b0}};
      r_m    <= {WIDTH{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_quot <= {WIDTH{1'b0}};
      r_rem  <= {WIDTH{1'b0}};
      r_dbz  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == CALC);
      r_done <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start && w_div_zero) begin
            r_quot <= {WIDTH{1'b1}};
            r_rem  <= bus.dividend;
            r_dbz  <= 1'b1;
          end else if (bus.start) begin
            r_a   <= {(WIDTH+1){1'b0}};
            r_q   <= bus.dividend;
            r_m   <= bus.divisor;
            r_cnt <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          r_a   <= w_a_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot <= w_q_step;
            r_rem  <= w_a_step[WIDTH-1:0];
            r_dbz  <= 1'b0;
          end
        end
        default: begin
          r_a <= r_a;
        end
      endcase
    end
  end

  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Self-checking bench for seq_divider_4bit: directed cases, exhaustive sweep and
// random traffic, all compared every cycle against an arithmetic reference model.
module tb_seq_divider_4bit;
  import seq_divider_4bit_pkg::*;

  localparam int W     = WIDTH_DEF;
  localparam int ALL1  = (1 << W) - 1;
  localparam int LAT_N = W + 1;
  localparam int LAT_Z = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_divider_4bit_if #(.WIDTH(W)) bus ();

  seq_divider_4bit #(.WIDTH(W), .CNT_W(CNT_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields its quotient/remainder W cycles later.
  int   m_left = 0;
  int   m_q = 0, m_r = 0, p_q = 0, p_r = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_q <= 0; m_r <= 0;
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_q <= p_q; m_r <= p_r; m_dbz <= 1'b0;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (bus.start) begin
      if (int'(bus.divisor) == 0) begin
        m_q <= ALL1; m_r <= int'(bus.dividend); m_dbz <= 1'b1; m_done <= 1'b1;
      end else begin
        p_q <= int'(bus.dividend) / int'(bus.divisor);
        p_r <= int'(bus.dividend) % int'(bus.divisor);
        m_left <= W; m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy",        int'(bus.busy),        int'(m_busy));
      chk("done",        int'(bus.done),        int'(m_done));
      chk("quotient",    int'(bus.quotient),    m_q);
      chk("remainder",   int'(bus.remainder),   m_r);
      chk("div_by_zero", int'(bus.div_by_zero), int'(m_dbz));
    end
  end

  task automatic run_div(input int dd, input int dv, input int exp_q, input int exp_r,
                         input int exp_dbz, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(dd);
    bus.divisor  = W'(dv);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom_range(ALL1));
    bus.divisor  = W'($urandom_range(ALL1));
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
    end
    chk("done_seen",  int'(bus.done), 1);
    chk("latency",    lat, exp_lat);
    chk("lit_q",      int'(bus.quotient), exp_q);
    chk("lit_r",      int'(bus.remainder), exp_r);
    chk("lit_dbz",    int'(bus.div_by_zero), exp_dbz);
  endtask

  initial begin
    int n_done, cap_q, cap_r;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_q",    int'(bus.quotient), 0);
    chk("rst_r",    int'(bus.remainder), 0);
    chk("rst_dbz",  int'(bus.div_by_zero), 0);
    rst = 1'b0;

    run_div(13, 3, 4, 1, 0, LAT_N);
    chk("model_pin_q", m_q, 4);
    run_div(15, 1, 15, 0, 0, LAT_N);
    run_div(7, 9, 0, 7, 0, LAT_N);
    repeat (5) @(negedge clk);
    chk("hold_q", int'(bus.quotient), 0);
    chk("hold_r", int'(bus.remainder), 7);
    run_div(9, 0, 15, 9, 1, LAT_Z);
    chk("model_pin_dbz", int'(m_dbz), 1);
    run_div(8, 2, 4, 0, 0, LAT_N);

    // Second start two cycles into CALC must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1; bus.dividend = 4'd3; bus.divisor = 4'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    n_done = 0; cap_q = -1; cap_r = -1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++; cap_q = int'(bus.quotient); cap_r = int'(bus.remainder);
      end
    end
    chk("busy_start_dones", n_done, 1);
    chk("busy_start_q", cap_q, 3);
    chk("busy_start_r", cap_r, 2);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_q",    int'(bus.quotient), 0);
    chk("abort_r",    int'(bus.remainder), 0);
    chk("abort_dbz",  int'(bus.div_by_zero), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_div(12, 5, 2, 2, 0, LAT_N);

    for (int dd = 0; dd <= ALL1; dd++) begin
      for (int dv = 0; dv <= ALL1; dv++) begin
        run_div(dd, dv, (dv == 0) ? ALL1 : dd / dv, (dv == 0) ? dd : dd % dv,
                (dv == 0) ? 1 : 0, (dv == 0) ? LAT_Z : LAT_N);
        if (dv != 0) begin
          chk("invariant", int'(bus.quotient) * dv + int'(bus.remainder), dd);
          chk("rem_lt_div", int'(int'(bus.remainder) < dv), 1);
        end
      end
    end

    // Random traffic, including starts that land in CALC/DONE.
    repeat (600) begin
      @(negedge clk);
      bus.start    = ($urandom_range(99) < 35);
      bus.dividend = W'($urandom_range(ALL1));
      bus.divisor  = ($urandom_range(9) == 0) ? '0 : W'($urandom_range(ALL1));
    end
    @(negedge clk) bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
